// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam int          XLEN       = 32;
  localparam int          INSN_BYTES = 4;
  localparam logic [31:0] NOP_INSN   = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: shift-register storage so the head is always a register output.
// Push and pop may coincide at any occupancy; flush empties it and wins over a push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;

  always_comb begin
    mem_d = mem_q;
    if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
    end
    // Write slot is computed after the shift so a full FIFO can push and pop together.
    wr_idx = count_q - CW'(pop_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && wr_idx == CW'(i)) mem_d[i] = push_dat_i;
    end
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: RESET_PC, insn: NOP_INSN};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[0];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues credit-limited in-order requests, drops stale responses.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] inst_data
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credit_used;
  logic          req_fire, rsp_fire, push, pop;
  fetch_entry_t  head;

  // Credits cover both in-flight requests and buffered words, so the FIFO cannot overflow.
  assign credit_used    = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign imem_req_valid = reset && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_fire = reset && imem_rsp_valid;
  assign push     = rsp_fire && !redirect_valid && (drop_q == '0);

  assign inst_valid = reset && (fifo_cnt != '0);
  assign inst_pc    = head.pc;
  assign inst_data  = head.insn;
  assign pop        = inst_valid && inst_ready;

  always_comb begin
    out_d = out_q + CW'(req_fire) - CW'(rsp_fire);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_d   = out_d;
      pc_d     = align_pc(redirect_pc);
      rsp_pc_d = align_pc(redirect_pc);
    end else begin
      drop_d   = (rsp_fire && drop_q != '0) ? drop_q - CW'(1) : drop_q;
      pc_d     = req_fire ? pc_q + 32'(INSN_BYTES) : pc_q;
      rsp_pc_d = push ? rsp_pc_q + 32'(INSN_BYTES) : rsp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .push_i    (push),
    .push_dat_i('{pc: rsp_pc_q, insn: imem_rsp_data}),
    .pop_i     (pop),
    .flush_i   (redirect_valid),
    .head_o    (head),
    .count_o   (fifo_cnt)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (inst_ready && !inst_valid) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-bench memory and instruction-stream model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_pc, inst_data;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
    .inst_data(inst_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, last_due = 0;
  int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, irdy_pct = 100, redir_pm = 0, rst_pm = 0;
  int          rst_hold = 0, fire_cnt = 0, rel_cyc = 0, first_valid = -1, delivered = 0;
  bit          redir_prev = 0, force_redir = 0;
  logic [31:0] force_pc = '0, redir_tgt = '0, gen_pc = RESET_PC, fetch_exp = RESET_PC;

  // Memory contents are a fixed hash of the address, so any word can be predicted from its PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(3))
      0:       return 32'hFFFFFFF0 | 32'($urandom_range(15));
      1:       return 32'h00000100 | 32'($urandom_range(3));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: one call per clock, inputs change on the falling edge.
  task automatic step();
    bit rst_req;
    @(negedge clk);
    cyc++;
    if (redir_prev) begin
      exp_q.delete();
      gen_pc = redir_tgt;
    end
    if (rst_hold == 0 && $urandom_range(999) < rst_pm) rst_hold = 2;
    rst_req = (rst_hold > 0);
    if (rst_hold > 0) rst_hold--;
    reset = !rst_req;
    if (rst_req) begin
      mem_q.delete();
      exp_q.delete();
      gen_pc   = RESET_PC;
      last_due = cyc;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < irdy_pct);
    redirect_valid = 1'b0;
    redirect_pc    = 32'($urandom);
    if (!rst_req && (force_redir || $urandom_range(999) < redir_pm)) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_redir ? force_pc : rand_tgt();
      redir_tgt      = {redirect_pc[31:2], 2'b00};
    end
    redir_prev     = redirect_valid;
    force_redir    = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'($urandom);
    if (!rst_req && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst_hold = n;
    run(n);
  endtask

  // Monitor: samples settled outputs mid-cycle and scores every handshake that commits at the next edge.
  bit          p_rst = 0, p_redir = 0, p_req_stall = 0, p_inst_stall = 0;
  logic [31:0] p_addr = '0, p_pc = '0, p_data = '0;

  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      if (p_rst) begin
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_inst_data", inst_data, NOP);
      end
      p_rst = 1; fetch_exp = RESET_PC; fire_cnt = 0; first_valid = -1;
      p_redir = 0; p_req_stall = 0; p_inst_stall = 0;
    end else begin
      if (p_rst) rel_cyc = cyc;
      if (p_req_stall && !redirect_valid) begin
        chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
        chk("req_hold_addr", imem_req_addr, p_addr);
      end
      if (p_inst_stall && !p_redir) begin
        chk("inst_hold_valid", 32'(inst_valid), 32'd1);
        chk("inst_hold_pc", inst_pc, p_pc);
        chk("inst_hold_data", inst_data, p_data);
      end
      if (redirect_valid) chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      if (p_redir) chk("flush_after_redirect", 32'(inst_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        int d;
        chk("req_addr", imem_req_addr, fetch_exp);
        fetch_exp += 32'd4;
        d = cyc + lat_lo + int'($urandom_range(lat_hi - lat_lo));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_q.push_back('{addr: imem_req_addr, due: d});
        fire_cnt++;
        chk("inflight_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
      end
      if (inst_valid && first_valid < 0) first_valid = cyc;
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst_data", inst_data, mem_word(e));
          delivered++;
        end
      end
      if (redirect_valid) fetch_exp = {redirect_pc[31:2], 2'b00};
      p_req_stall  = imem_req_valid && !imem_req_ready;
      p_addr       = imem_req_addr;
      p_inst_stall = inst_valid && !inst_ready;
      p_pc         = inst_pc;
      p_data       = inst_data;
      p_redir      = redirect_valid;
      p_rst        = 0;
    end
  end

  typedef struct {
    int lat_lo, lat_hi, rdy, irdy, redir, rst;
  } phase_t;

  phase_t phases[4] = '{
    '{1, 1, 100, 100, 20, 0},
    '{1, 4,  50,  60, 30, 2},
    '{3, 3,  80,  40, 15, 2},
    '{1, 6,  30,  90, 50, 3}
  };

  initial begin
    reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Streaming from reset: first instruction two cycles after release.
    do_reset(3);
    run(12);
    #3;
    chk("first_valid_latency", 32'(first_valid - rel_cyc), 32'd2);

    // Decode stalled: credits cap fetching at DEPTH requests.
    irdy_pct = 0;
    do_reset(2);
    run(12);
    #3;
    chk("stall_req_count", 32'(fire_cnt), 32'(DEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    chk("stall_inst_pc", inst_pc, RESET_PC);
    irdy_pct = 100;
    run(10);

    // Redirect with two slow responses in flight; both must be dropped.
    lat_lo = 3; lat_hi = 3;
    do_reset(2);
    run(2);
    force_redir = 1; force_pc = 32'h00000103;
    run(15);

    // Steady-state redirect (coincides with a response and a pop) to the top of the address space.
    lat_lo = 1; lat_hi = 1;
    run(3);
    force_redir = 1; force_pc = 32'hFFFFFFFE;
    run(10);

    foreach (phases[p]) begin
      lat_lo = phases[p].lat_lo; lat_hi = phases[p].lat_hi;
      rdy_pct = phases[p].rdy; irdy_pct = phases[p].irdy;
      redir_pm = phases[p].redir * 10; rst_pm = phases[p].rst;
      run(2000);
    end
    rst_pm = 0; redir_pm = 0;
    run(5);
    #3;
    chk("progress", 32'(delivered > 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
